graph_loader: RTL and testbench
===============================

# graph_loader

Upstream stage of the shortest-path engine. Accepts a graph as a stream of edges over a valid/ready handshake, packs them into the 256-entry × 12-bit edge array, derives node and edge counts, then presents the complete graph to the Dijkstra block. It holds the graph stable until the engine reports completion. One graph is in flight at a time.

## Interface
- `NODE_W`, default 4: node index width; also the weight width.
- `MAX_E`, default 255: maximum number of edges per graph. It fits the 8-bit edge count.
- `EDGE_W`, default 12: packed edge width. Bits [3:0] are the parent, [7:4] the child, [11:8] the weight.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream edge valid.
- `in_ready`  out  1  loader can accept an edge.
- `in_parent`  in  4  parent node of the edge.
- `in_child`  in  4  child node of the edge.
- `in_weight`  in  4  edge weight.
- `in_last`  in  1  marks the final edge of the graph.
- `n`  out  4  highest node index referenced. Nodes 0..n exist.
- `e`  out  8  number of stored edges.
- `data`  out  12 × 256  packed edge array. Entries at index ≥ e are 0.
- `valid`  out  1  one-cycle start pulse to the Dijkstra block.
- `sp_done`  in  1  connected to the Dijkstra block's `valid_out`.
- `trunc`  out  1  set when the graph was cut off at MAX_E edges. Cleared at the start of the next graph.
- `busy`  out  1  high in ISSUE and WAIT.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT.
- An edge is accepted on a cycle with `in_valid && in_ready`.
- Accepted edge handling:
  - writes `{weight, child, parent}` to `data[e]`;
  - sets e ← e+1;
  - sets n ← max(n, parent, child).
- IDLE:
  - `in_ready` = 1.
  - Accepting an edge clears `trunc` and moves to LOAD, or to ISSUE if `in_last`.
  - On that first edge, n and e start from 0.
- LOAD:
  - `in_ready` = 1.
  - Accepting an edge with `in_last` = 1 moves to ISSUE.
  - Accepting the MAX_E-th edge without `in_last` sets `trunc` = 1 and moves to ISSUE. That edge is treated as last.
  - Further upstream edges wait, because `in_ready` = 0 outside IDLE/LOAD.
- ISSUE:
  - `valid` = 1 for exactly this cycle.
  - Next state is WAIT, or IDLE if `sp_done` = 1 in this cycle.
- WAIT:
  - `in_ready` = 0.
  - n, e and data are held stable.
  - On `sp_done` = 1, move to IDLE. In the same edge, clear all data entries to 0 and clear n and e.
- `sp_done` is ignored in IDLE and LOAD.
- No filtering of edge content:
  - self-loops (parent == child), zero weights and duplicate edges are stored as given;
  - edge order is preserved, so `data[i]` is the i-th accepted edge.
- Reset values:
  - state IDLE, `in_ready` = 1;
  - `valid` = 0, `busy` = 0, `trunc` = 0;
  - n = 0, e = 0, all data entries 0.
- Reset mid-graph or mid-wait discards everything. No `valid` is issued for the partial graph.

## Timing
- `in_ready` is a registered function of state only. It has no combinational path from `in_valid`.
- `valid` rises in the cycle after the last edge is accepted. Latency is 1 clock from the last handshake.
- n and e are registered. They reflect all accepted edges from the ISSUE cycle onward.
- The data write and the n/e update take effect on the same edge as the handshake.
- After `sp_done` is sampled in WAIT, `in_ready` is 1 on the next cycle. The minimum gap between graphs is therefore 1 cycle.
- Throughput in LOAD is 1 edge/cycle. An L-edge graph occupies L cycles of input, plus 1 cycle of ISSUE, plus the Dijkstra runtime.

## Structure
- Shared package `graph_pkg` holds:
  - the NODE_W, EDGE_W and MAX_E constants;
  - the `edge_t` packed struct {weight, child, parent}, with parent in the LSBs;
  - the `loader_state_t` enum.
- The Dijkstra block imports the same package for edge decoding.
- One sub-module is natural: `edge_store`. It is the 256 × 12 register array with one write port, a synchronous clear-all, and parallel read-out.
- The FSM, the counters and the max-index tracker stay in `graph_loader`.

## Test plan
- Three-edge graph (0→1 w3), (1→2 w2), (0→2 w7), last on the third edge, back-to-back:
  - `valid` pulses 1 cycle after the third handshake;
  - e = 3, n = 2;
  - data[0..2] = 0x310, 0x221, 0x720; data[3] = 0.
- Single edge 5→5 w0 with `in_last` in IDLE:
  - ISSUE on the next cycle, with e = 1, n = 5, data[0] = 0x055.
- 300 edges streamed without `in_last`:
  - exactly 255 are accepted;
  - `trunc` = 1 and e = 255;
  - `in_ready` drops after the 255th handshake.
- Hold `sp_done` low for 20 cycles in WAIT, driving `in_valid` = 1 throughout:
  - `in_ready` stays 0 and data is unchanged;
  - a `sp_done` pulse returns to IDLE with data all 0.
- Assert `reset` after 4 of 6 edges:
  - all outputs return to their reset values;
  - no `valid` is issued;
  - a new 2-edge graph then loads correctly from index 0.
- `sp_done` = 1 during the ISSUE cycle:
  - next state is IDLE;
  - `sp_done` pulses in IDLE/LOAD cause no state change.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared definitions for the shortest-path engine: graph size constants,
// the packed edge format and the loader FSM state encoding.
package graph_pkg;

    localparam int unsigned NODE_W = 4;
    localparam int unsigned EDGE_W = 12;
    localparam int unsigned MAX_E  = 255;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned CNT_W  = 8;

    // Parent sits in the LSBs so the packed word reads {weight, child, parent}.
    typedef struct packed {
        logic [NODE_W-1:0] weight;
        logic [NODE_W-1:0] child;
        logic [NODE_W-1:0] parent;
    } edge_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } loader_state_t;

    function automatic logic [NODE_W-1:0] node_max(input logic [NODE_W-1:0] a,
                                                   input logic [NODE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_store.sv
// Edge array: DEPTH x EDGE_W registers, one write port, synchronous
// clear-all, every entry visible in parallel on the flat data bus.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : zero every entry on this edge (wins over we)
//   we/waddr/wdata : single write port
//   data        : entry i at data[i*EDGE_W +: EDGE_W]
module edge_store
    import graph_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     we,
    input  logic [CNT_W-1:0]         waddr,
    input  logic [EDGE_W-1:0]        wdata,
    output logic [DEPTH*EDGE_W-1:0]  data
);

    logic [EDGE_W-1:0] mem [DEPTH];

    // Storage: clear-all has priority over the write port.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Parallel read-out.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_rd
        assign data[g*EDGE_W +: EDGE_W] = mem[g];
    end

endmodule

// File: rtl/graph_loader.sv
// Accepts a graph as a valid/ready edge stream, packs it into the edge
// array, tracks node/edge counts, then pulses valid to the Dijkstra block
// and holds the graph until sp_done.
//   clk, reset                     : clock, synchronous active-high reset
//   in_valid/in_ready              : upstream edge handshake
//   in_parent/in_child/in_weight   : edge fields, in_last marks final edge
//   n, e, data                     : highest node index, edge count, edge array
//   valid                          : one-cycle start pulse
//   sp_done                        : engine completion
//   trunc                          : graph was cut at MAX_E edges
//   busy                           : high in ISSUE and WAIT
module graph_loader #(
    parameter int unsigned NODE_W = 4,
    parameter int unsigned MAX_E  = 255,
    parameter int unsigned EDGE_W = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NODE_W-1:0]                   in_parent,
    input  logic [NODE_W-1:0]                   in_child,
    input  logic [NODE_W-1:0]                   in_weight,
    input  logic                                in_last,
    output logic [NODE_W-1:0]                   n,
    output logic [graph_pkg::CNT_W-1:0]         e,
    output logic [graph_pkg::DEPTH*EDGE_W-1:0]  data,
    output logic                                valid,
    input  logic                                sp_done,
    output logic                                trunc,
    output logic                                busy
);

    localparam int unsigned CNT_W = graph_pkg::CNT_W;

    graph_pkg::loader_state_t state, state_d;

    logic [NODE_W-1:0]  n_d;
    logic [CNT_W-1:0]   e_d;
    logic               trunc_d;
    logic               we;
    logic               clr;
    logic [CNT_W-1:0]   waddr;
    graph_pkg::edge_t   wr_edge;
    logic               accept;
    logic [NODE_W-1:0]  edge_max;

    assign accept   = in_valid && in_ready;
    assign edge_max = graph_pkg::node_max(in_parent, in_child);

    // Next-state, counter and store-control logic.
    always_comb begin
        state_d = state;
        n_d     = n;
        e_d     = e;
        trunc_d = trunc;
        we      = 1'b0;
        clr     = 1'b0;
        waddr   = e;
        wr_edge = '{weight: in_weight, child: in_child, parent: in_parent};

        unique case (state)
            graph_pkg::ST_IDLE: begin
                if (accept) begin
                    // First edge of a new graph always lands at index 0.
                    we      = 1'b1;
                    waddr   = '0;
                    e_d     = CNT_W'(1);
                    n_d     = edge_max;
                    trunc_d = 1'b0;
                    state_d = in_last ? graph_pkg::ST_ISSUE : graph_pkg::ST_LOAD;
                end
            end
            graph_pkg::ST_LOAD: begin
                if (accept) begin
                    we  = 1'b1;
                    e_d = e + CNT_W'(1);
                    n_d = graph_pkg::node_max(n, edge_max);
                    if (in_last) begin
                        state_d = graph_pkg::ST_ISSUE;
                    end else if (e_d == CNT_W'(MAX_E)) begin
                        trunc_d = 1'b1;
                        state_d = graph_pkg::ST_ISSUE;
                    end
                end
            end
            graph_pkg::ST_ISSUE: begin
                if (sp_done) begin
                    // Early completion: release the graph exactly as from WAIT.
                    state_d = graph_pkg::ST_IDLE;
                    clr     = 1'b1;
                    n_d     = '0;
                    e_d     = '0;
                end else begin
                    state_d = graph_pkg::ST_WAIT;
                end
            end
            graph_pkg::ST_WAIT: begin
                if (sp_done) begin
                    state_d = graph_pkg::ST_IDLE;
                    clr     = 1'b1;
                    n_d     = '0;
                    e_d     = '0;
                end
            end
            default: state_d = graph_pkg::ST_IDLE;
        endcase
    end

    // State, counters and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= graph_pkg::ST_IDLE;
            n        <= '0;
            e        <= '0;
            trunc    <= 1'b0;
            in_ready <= 1'b1;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            n        <= n_d;
            e        <= e_d;
            trunc    <= trunc_d;
            in_ready <= (state_d == graph_pkg::ST_IDLE) || (state_d == graph_pkg::ST_LOAD);
            valid    <= (state_d == graph_pkg::ST_ISSUE);
            busy     <= (state_d == graph_pkg::ST_ISSUE) || (state_d == graph_pkg::ST_WAIT);
        end
    end

    edge_store u_store (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .we    (we),
        .waddr (waddr),
        .wdata (EDGE_W'(wr_edge)),
        .data  (data)
    );

endmodule

// File: tb/tb_graph_loader.sv
// Directed bench for graph_loader: inputs change 1 time unit after the
// rising edge, outputs are sampled at the same point.
module tb_graph_loader;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_parent;
    logic [3:0]    in_child;
    logic [3:0]    in_weight;
    logic          in_last;
    logic [3:0]    n;
    logic [7:0]    e;
    logic [3071:0] data;
    logic          valid;
    logic          sp_done;
    logic          trunc;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    graph_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_parent (in_parent),
        .in_child  (in_child),
        .in_weight (in_weight),
        .in_last   (in_last),
        .n         (n),
        .e         (e),
        .data      (data),
        .valid     (valid),
        .sp_done   (sp_done),
        .trunc     (trunc),
        .busy      (busy)
    );

    function automatic logic [11:0] ent(input int i);
        return data[i*12 +: 12];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_edge(input logic [3:0] p, input logic [3:0] c,
                              input logic [3:0] w, input logic last);
        in_valid  = 1'b1;
        in_parent = p;
        in_child  = c;
        in_weight = w;
        in_last   = last;
        tick();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        sp_done  = 1'b0;
    endtask

    task automatic pulse_done();
        sp_done = 1'b1;
        tick();
        sp_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        in_parent = '0; in_child = '0; in_weight = '0;
        tick(); tick();
        reset = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (trunc !== 1'b0) begin bad++; $display("FAIL reset_trunc got=%b exp=0", trunc); end
        total++; if (n !== 4'd0 || e !== 8'd0) begin bad++; $display("FAIL reset_ne got n=%0d e=%0d exp 0 0", n, e); end
        total++; if (data !== '0) begin bad++; $display("FAIL reset_data got nonzero exp=0"); end
    endtask

    task automatic test_three_edge();
        drive_edge(4'd0, 4'd1, 4'd3, 1'b0);
        drive_edge(4'd1, 4'd2, 4'd2, 1'b0);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL three_early_valid got=%b exp=0", valid); end
        drive_edge(4'd0, 4'd2, 4'd7, 1'b1);
        idle_inputs();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL three_valid got=%b exp=1", valid); end
        total++; if (e !== 8'd3) begin bad++; $display("FAIL three_e got=%0d exp=3", e); end
        total++; if (n !== 4'd2) begin bad++; $display("FAIL three_n got=%0d exp=2", n); end
        total++; if (ent(0) !== 12'h310) begin bad++; $display("FAIL three_d0 got=%h exp=310", ent(0)); end
        total++; if (ent(1) !== 12'h221) begin bad++; $display("FAIL three_d1 got=%h exp=221", ent(1)); end
        total++; if (ent(2) !== 12'h720) begin bad++; $display("FAIL three_d2 got=%h exp=720", ent(2)); end
        total++; if (ent(3) !== 12'h000) begin bad++; $display("FAIL three_d3 got=%h exp=000", ent(3)); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL three_issue_flags got busy=%b rdy=%b exp 1 0", busy, in_ready); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL three_valid_width got=%b exp=0", valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL three_wait_busy got=%b exp=1", busy); end
        pulse_done();
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL three_release got rdy=%b busy=%b exp 1 0", in_ready, busy); end
        total++; if (data !== '0 || e !== 8'd0 || n !== 4'd0) begin bad++; $display("FAIL three_cleared got e=%0d n=%0d exp 0 0 and zero data", e, n); end
    endtask

    task automatic test_single_edge();
        drive_edge(4'd5, 4'd5, 4'd0, 1'b1);
        idle_inputs();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", valid); end
        total++; if (e !== 8'd1 || n !== 4'd5) begin bad++; $display("FAIL single_ne got e=%0d n=%0d exp 1 5", e, n); end
        total++; if (ent(0) !== 12'h055) begin bad++; $display("FAIL single_d0 got=%h exp=055", ent(0)); end
        total++; if (trunc !== 1'b0) begin bad++; $display("FAIL single_trunc got=%b exp=0", trunc); end
        tick();
        pulse_done();
    endtask

    task automatic test_truncate();
        int accepted = 0;
        int pulses   = 0;
        int drop_at  = -1;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'b1;
            in_last   = 1'b0;
            in_parent = 4'(i % 16);
            in_child  = 4'((i + 1) % 16);
            in_weight = 4'(i % 16);
            if (in_ready === 1'b1) accepted++;
            tick();
            if (valid === 1'b1) pulses++;
            if (drop_at < 0 && in_ready === 1'b0) drop_at = i;
        end
        idle_inputs();
        total++; if (accepted != 255) begin bad++; $display("FAIL trunc_accepted got=%0d exp=255", accepted); end
        total++; if (drop_at != 254) begin bad++; $display("FAIL trunc_ready_drop got=%0d exp=254", drop_at); end
        total++; if (pulses != 1) begin bad++; $display("FAIL trunc_valid_pulses got=%0d exp=1", pulses); end
        total++; if (trunc !== 1'b1) begin bad++; $display("FAIL trunc_flag got=%b exp=1", trunc); end
        total++; if (e !== 8'd255 || n !== 4'd15) begin bad++; $display("FAIL trunc_ne got e=%0d n=%0d exp 255 15", e, n); end
        total++; if (ent(254) !== 12'hEFE || ent(0) !== 12'h010 || ent(255) !== 12'h000) begin
            bad++; $display("FAIL trunc_data got d254=%h d0=%h d255=%h exp EFE 010 000", ent(254), ent(0), ent(255));
        end
        pulse_done();
        total++; if (trunc !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL trunc_hold_idle got trunc=%b rdy=%b exp 1 1", trunc, in_ready); end
    endtask

    task automatic test_wait_hold();
        drive_edge(4'd3, 4'd4, 4'd9, 1'b0);
        total++; if (trunc !== 1'b0) begin bad++; $display("FAIL hold_trunc_clear got=%b exp=0", trunc); end
        drive_edge(4'd4, 4'd6, 4'd1, 1'b1);
        drive_edge(4'd7, 4'd8, 4'd5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (in_ready !== 1'b0 || e !== 8'd2 || n !== 4'd6 || ent(0) !== 12'h943 || ent(1) !== 12'h164 || ent(2) !== 12'h000) begin
                bad++;
                $display("FAIL hold_cycle%0d got rdy=%b e=%0d n=%0d d0=%h d1=%h d2=%h exp 0 2 6 943 164 000",
                         i, in_ready, e, n, ent(0), ent(1), ent(2));
            end
            tick();
        end
        pulse_done();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_release got rdy=%b busy=%b exp 1 0", in_ready, busy); end
        total++; if (data !== '0 || e !== 8'd0) begin bad++; $display("FAIL hold_cleared got e=%0d d0=%h exp 0 000", e, ent(0)); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        drive_edge(4'd1, 4'd2, 4'd1, 1'b0);
        drive_edge(4'd2, 4'd3, 4'd1, 1'b0);
        drive_edge(4'd3, 4'd4, 4'd1, 1'b0);
        drive_edge(4'd4, 4'd5, 4'd1, 1'b0);
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (valid === 1'b1) pulses++;
        tick();
        if (valid === 1'b1) pulses++;
        total++; if (pulses != 0) begin bad++; $display("FAIL rmid_valid got=%0d pulses exp=0", pulses); end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || trunc !== 1'b0) begin bad++; $display("FAIL rmid_flags got rdy=%b busy=%b trunc=%b exp 1 0 0", in_ready, busy, trunc); end
        total++; if (e !== 8'd0 || n !== 4'd0 || data !== '0) begin bad++; $display("FAIL rmid_state got e=%0d n=%0d exp 0 0 and zero data", e, n); end
        drive_edge(4'd2, 4'd3, 4'd4, 1'b0);
        drive_edge(4'd1, 4'd0, 4'd6, 1'b1);
        idle_inputs();
        total++; if (valid !== 1'b1 || e !== 8'd2 || n !== 4'd3) begin bad++; $display("FAIL rmid_reload got v=%b e=%0d n=%0d exp 1 2 3", valid, e, n); end
        total++; if (ent(0) !== 12'h432 || ent(1) !== 12'h601 || ent(2) !== 12'h000) begin bad++; $display("FAIL rmid_data got %h %h %h exp 432 601 000", ent(0), ent(1), ent(2)); end
        tick();
        pulse_done();
    endtask

    task automatic test_done_in_issue();
        drive_edge(4'd1, 4'd2, 4'd3, 1'b1);
        idle_inputs();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL issue_valid got=%b exp=1", valid); end
        pulse_done();
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL issue_to_idle got rdy=%b busy=%b v=%b exp 1 0 0", in_ready, busy, valid); end
        pulse_done();
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_done_ignored got rdy=%b busy=%b exp 1 0", in_ready, busy); end
        drive_edge(4'd0, 4'd1, 4'd1, 1'b0);
        idle_inputs();
        pulse_done();
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || e !== 8'd1) begin bad++; $display("FAIL load_done_ignored got rdy=%b busy=%b e=%0d exp 1 0 1", in_ready, busy, e); end
        drive_edge(4'd1, 4'd3, 4'd2, 1'b1);
        idle_inputs();
        total++; if (valid !== 1'b1 || e !== 8'd2 || n !== 4'd3 || ent(1) !== 12'h231) begin
            bad++; $display("FAIL load_resume got v=%b e=%0d n=%0d d1=%h exp 1 2 3 231", valid, e, n, ent(1));
        end
        tick();
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_three_edge();
        test_single_edge();
        test_truncate();
        test_wait_hold();
        test_reset_mid();
        test_done_in_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
